// File: rtl/mwsub_seq_pkg.sv
// Shared types and constants for the multi-word sequential subtractor.
package mwsub_seq_pkg;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mwsub_seq_sub_word32.sv
// One 32-bit subtract slice with borrow in/out; time-shared by mwsub_seq.
module sub_word32
    import mwsub_seq_pkg::*;
(
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              bin,
    output logic [WORD_W-1:0] diff,
    output logic              bout
);
    logic [WORD_W:0] res;

    // The 33rd bit goes negative exactly when A < B + bin.
    assign res  = {1'b0, A} - {1'b0, B} - {{WORD_W{1'b0}}, bin};
    assign diff = res[WORD_W-1:0];
    assign bout = res[WORD_W];
endmodule

// File: rtl/mwsub_seq.sv
// Sequential multi-word subtractor: one 32-bit word per cycle, LSW first.
// Define MWSUB_SAT_EN to saturate a negative result to zero.
module mwsub_seq
    import mwsub_seq_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [32*NWORDS-1:0]     A,
    input  logic [32*NWORDS-1:0]     B,
    input  logic                     Bin,
    output logic                     busy,
    output logic                     done,
    output logic [32*NWORDS-1:0]     Diff,
    output logic                     Bout,
    output logic                     Z,
    output logic                     N
);
    localparam int             IW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0]  LAST = IW'(NWORDS - 1);

    state_t                          state, state_nx;
    logic [NWORDS-1:0][WORD_W-1:0]   a_q, b_q, diff_q;
    logic [IW-1:0]                   idx;
    logic                            brw, zacc;
    logic [WORD_W-1:0]               wdiff;
    logic                            wbout;

    sub_word32 u_sub (
        .A    (a_q[idx]),
        .B    (b_q[idx]),
        .bin  (brw),
        .diff (wdiff),
        .bout (wbout)
    );

    assign Diff = diff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (idx == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    // brw carries Bin into word 0 and the previous word's borrow afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            idx    <= '0;
            brw    <= 1'b0;
            zacc   <= 1'b0;
            Bout   <= 1'b0;
            Z      <= 1'b0;
            N      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q    <= A;
                    b_q    <= B;
                    brw    <= Bin;
                    idx    <= '0;
                    zacc   <= 1'b1;
                    diff_q <= '0;
                    Bout   <= 1'b0;
                    Z      <= 1'b0;
                    N      <= 1'b0;
                end
                RUN: begin
                    diff_q[idx] <= wdiff;
                    brw         <= wbout;
                    zacc        <= zacc & (wdiff == '0);
                    if (idx == LAST) begin
                        Bout <= wbout;
                        Z    <= zacc & (wdiff == '0);
                        N    <= wdiff[WORD_W-1];
`ifdef MWSUB_SAT_EN
                        if (wbout) begin
                            diff_q <= '0;
                            Z      <= 1'b1;
                            N      <= 1'b0;
                        end
`else
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mwsub_seq.sv
// Randomized bench for mwsub_seq (NWORDS=4) against a whole-operand arithmetic model.
module tb_mwsub_seq;
    localparam int NW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [127:0]   A = '0, B = '0;
    logic           Bin = 1'b0;
    logic           busy, done, Bout, Z, N;
    logic [127:0]   Diff;

    int nchk = 0;
    int nfail = 0;

    mwsub_seq #(.NWORDS(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
        .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .Z(Z), .N(N)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] lowmask(input int k);
        if (k >= NW) return '1;
        return (128'd1 << (32 * k)) - 128'd1;
    endfunction

    // Model: the whole 128-bit difference is computed at capture; k edges after
    // capture the low k words of it are visible, flags appear with the last word.
    logic         m_act;
    int           m_k;
    logic [128:0] m_full;
    logic [127:0] m_diff;
    logic         m_bout, m_z, m_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0; m_k <= 0; m_full <= '0;
            m_diff <= '0; m_bout <= 1'b0; m_z <= 1'b0; m_n <= 1'b0;
        end else if (!m_act) begin
            if (start) begin
                m_act  <= 1'b1;
                m_k    <= 0;
                m_full <= {1'b0, A} - {1'b0, B} - 129'(Bin);
                m_diff <= '0; m_bout <= 1'b0; m_z <= 1'b0; m_n <= 1'b0;
            end
        end else if (m_k == NW) begin
            m_act <= 1'b0;
        end else begin
            m_k    <= m_k + 1;
            m_diff <= m_full[127:0] & lowmask(m_k + 1);
            if (m_k + 1 == NW) begin
                m_bout <= m_full[128];
                m_z    <= (m_full[127:0] == '0);
                m_n    <= m_full[127];
`ifdef MWSUB_SAT_EN
                if (m_full[128]) begin
                    m_diff <= '0; m_z <= 1'b1; m_n <= 1'b0;
                end
`else
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 128'(busy), 128'(m_act));
            chk("done", 128'(done), 128'(m_act && m_k == NW));
            chk("Diff", Diff, m_diff);
            chk("Bout", 128'(Bout), 128'(m_bout));
            chk("Z", 128'(Z), 128'(m_z));
            chk("N", 128'(N), 128'(m_n));
        end
    end

    task automatic op(input logic [127:0] a, input logic [127:0] b, input logic bi,
                      input logic [127:0] ed, input logic eb, input logic ez, input logic en);
        int n;
        @(posedge clk); #1; A = a; B = b; Bin = bi; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; n = 0;
        while (!done && n < 30) begin @(posedge clk); #1; n++; end
        chk("latency", n, NW);
        chk("lit_Diff", Diff, ed);
        chk("lit_Bout", 128'(Bout), 128'(eb));
        chk("lit_Z", 128'(Z), 128'(ez));
        chk("lit_N", 128'(N), 128'(en));
        @(posedge clk); #1;
        chk("done_once", 128'(done), 128'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin @(posedge clk); #1; n++; end
        chk("idle_timeout", 128'(busy), 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        case ($urandom % 4)
            0:       return '0;
            1:       return '1;
            default: return {$urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        #1;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_Diff", Diff, 128'd0);

        op(128'd2, 128'd1, 1'b0, 128'd1, 1'b0, 1'b0, 1'b0);
        op(128'h1_00000000, 128'd1, 1'b0, 128'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
`ifdef MWSUB_SAT_EN
        op(128'd0, 128'd0, 1'b1, 128'd0, 1'b1, 1'b1, 1'b0);
`else
        op(128'd0, 128'd0, 1'b1, '1, 1'b1, 1'b0, 1'b1);
`endif
        op(128'd5, 128'd5, 1'b0, 128'd0, 1'b0, 1'b1, 1'b0);

        // start during RUN and during DONE with other operands must be ignored
        @(posedge clk); #1; A = 128'd2; B = 128'd1; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1; A = rnd128(); B = 128'd77;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ign_done", 128'(done), 128'd1);
        start = 1'b1; A = 128'd900; B = 128'd3;
        @(posedge clk); #1; start = 1'b0;
        chk("ign_busy", 128'(busy), 128'd0);
        chk("ign_Diff", Diff, 128'd1);

        // random traffic with operand churn, ignored starts and rare async resets
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            start = ($urandom % 3 == 0);
            A = rnd128();
            B = ($urandom % 6 == 0) ? A : rnd128();
            Bin = $urandom % 2;
            if ($urandom % 120 == 0) begin rst = 1'b1; #1; rst = 1'b0; end
        end
        start = 1'b0;
        wait_idle();

        // reset mid-RUN clears everything immediately; next start is accepted
        @(posedge clk); #1; A = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321; B = 128'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; rst = 1'b1; #1;
        chk("mid_busy", 128'(busy), 128'd0);
        chk("mid_done", 128'(done), 128'd0);
        chk("mid_Diff", Diff, 128'd0);
        chk("mid_flags", {125'd0, Bout, Z, N}, 128'd0);
        @(posedge clk); #1; rst = 1'b0; A = 128'd10; B = 128'd4; start = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_accept", 128'(busy), 128'd1);
        start = 1'b0;
        repeat (NW + 1) @(posedge clk);
        #1;
        chk("post_rst_Diff", Diff, 128'd6);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end
endmodule
